// File: rtl/red_blob_bbox_detector.sv
// red_blob_bbox_detector: Avalon-ST pass-through that boxes red pixels per frame and overlays the result
module red_blob_bbox_detector #(
    parameter int          IMAGE_W    = 640,
    parameter int          IMAGE_H    = 480,
    parameter logic [7:0]  R_MIN      = 8'd160,
    parameter logic [7:0]  G_MAX      = 8'd80,
    parameter logic [7:0]  B_MAX      = 8'd80,
    parameter logic [23:0] HL_COLOUR  = 24'hFF0000,
    parameter logic [23:0] BOX_COLOUR = 24'h00FF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mode,
    input  logic [23:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic        sink_ready,
    output logic [23:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    output logic [31:0] s_readdata
);
    localparam logic [15:0] X_LAST = 16'(IMAGE_W - 1);
    localparam logic [15:0] Y_LAST = 16'(IMAGE_H - 1);

    logic [15:0] x, y, min_x, min_y, max_x, max_y, lmin_x, lmin_y, lmax_x, lmax_y, frame_cnt;
    logic [15:0] nmin_x, nmin_y, nmax_x, nmax_y;
    logic [19:0] hit_cnt, l_hit_cnt, hit_cnt_nx;
    logic        in_video, box_valid, accept, pix, hit, border;
    logic [23:0] pix_out;

    assign sink_ready = source_ready | ~source_valid;
    assign accept     = sink_valid & sink_ready;
    assign pix        = accept & ~sink_sop & in_video;
    assign hit        = (sink_data[23:16] >= R_MIN) && (sink_data[15:8] < G_MAX) && (sink_data[7:0] < B_MAX);

    always_comb begin
        nmin_x     = (hit && x < min_x) ? x : min_x;
        nmin_y     = (hit && y < min_y) ? y : min_y;
        nmax_x     = (hit && x > max_x) ? x : max_x;
        nmax_y     = (hit && y > max_y) ? y : max_y;
        hit_cnt_nx = (hit && hit_cnt != '1) ? hit_cnt + 20'd1 : hit_cnt;
        border     = box_valid &&
                     ((((x == lmin_x) || (x == lmax_x)) && y >= lmin_y && y <= lmax_y) ||
                      (((y == lmin_y) || (y == lmax_y)) && x >= lmin_x && x <= lmax_x));
        pix_out    = !(mode && pix) ? sink_data : border ? BOX_COLOUR : hit ? HL_COLOUR : sink_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            source_data  <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
        end else if (accept) begin
            source_data  <= pix_out;
            source_valid <= 1'b1;
            source_sop   <= sink_sop;
            source_eop   <= sink_eop;
        end else if (source_ready) begin
            source_valid <= 1'b0;
        end
    end

    // An SOP always restarts the running box, which also discards a truncated frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x         <= '0;
            y         <= '0;
            in_video  <= 1'b0;
            min_x     <= '1;
            min_y     <= '1;
            max_x     <= '0;
            max_y     <= '0;
            hit_cnt   <= '0;
            lmin_x    <= '0;
            lmin_y    <= '0;
            lmax_x    <= '0;
            lmax_y    <= '0;
            l_hit_cnt <= '0;
            box_valid <= 1'b0;
            frame_cnt <= '0;
        end else if (accept && sink_sop) begin
            in_video <= (sink_data[3:0] == 4'h0);
            x        <= '0;
            y        <= '0;
            min_x    <= '1;
            min_y    <= '1;
            max_x    <= '0;
            max_y    <= '0;
            hit_cnt  <= '0;
        end else if (pix) begin
            x <= (x == X_LAST) ? '0 : x + 16'd1;
            y <= (x == X_LAST && y != Y_LAST) ? y + 16'd1 : y;
            if (sink_eop) begin
                lmin_x    <= nmin_x;
                lmin_y    <= nmin_y;
                lmax_x    <= nmax_x;
                lmax_y    <= nmax_y;
                l_hit_cnt <= hit_cnt_nx;
                box_valid <= (hit_cnt_nx != '0);
                frame_cnt <= frame_cnt + 16'd1;
                min_x     <= '1;
                min_y     <= '1;
                max_x     <= '0;
                max_y     <= '0;
                hit_cnt   <= '0;
                in_video  <= 1'b0;
            end else begin
                min_x   <= nmin_x;
                min_y   <= nmin_y;
                max_x   <= nmax_x;
                max_y   <= nmax_y;
                hit_cnt <= hit_cnt_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s_readdata <= '0;
        else if (s_read)
            s_readdata <= (s_address == 2'd0) ? {lmin_x, lmin_y} :
                          (s_address == 2'd1) ? {lmax_x, lmax_y} :
                          (s_address == 2'd2) ? {12'b0, l_hit_cnt} :
                                                {frame_cnt, 15'b0, box_valid};
    end
endmodule
